k_wctl_g: RTL and testbench

Write-side control for the asynchronous FIFO; it is the write-domain counterpart of the read-side control. It owns the write pointer in binary and Gray form and synchronizes the read-domain Gray pointer into `wclk`. It produces the memory write enable and address, plus registered full, almost-full, fill-count and sticky overflow status. It sits between the producer and the dual-port FIFO memory, and exports `wptr` to the read domain's synchronizer.

---
 rtl/k_wctl_g_if.sv | 26 ++
 rtl/k_wctl_g.sv | 73 +++++++
 tb/tb_k_wctl_g.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/k_wctl_g_if.sv
// Producer/memory-facing signal bundle for the async FIFO write-side control.
// The master side is the producer and the read-domain pointer source; the slave side is k_wctl_g.
interface k_wctl_g_if #(
  parameter int addr_size = 4
);
  logic                 wput;
  logic                 wclr_ovf;
  logic [addr_size:0]   rptr;
  logic                 wen;
  logic [addr_size-1:0] waddr;
  logic [addr_size:0]   wptr;
  logic                 wfull;
  logic                 walmost_full;
  logic [addr_size:0]   wcount;
  logic                 woverflow;

  modport master (
    output wput, wclr_ovf, rptr,
    input  wen, waddr, wptr, wfull, walmost_full, wcount, woverflow
  );

  modport slave (
    input  wput, wclr_ovf, rptr,
    output wen, waddr, wptr, wfull, walmost_full, wcount, woverflow
  );
endinterface

// File: rtl/k_wctl_g.sv
// Async FIFO write-side control: it holds the binary and Gray write pointers and synchronises the read Gray pointer into wclk.
// Full, almost-full and fill count are derived from that stale read pointer, so they can only overstate the fill level.
module k_wctl_g #(
  parameter int addr_size    = 4,
  parameter int afull_margin = 2
) (
  input  logic      wclk,
  input  logic      wrst_n,
  k_wctl_g_if.slave bus
);
  localparam logic [addr_size:0] afull_level = (addr_size+1)'((1 << addr_size) - afull_margin);

  logic [addr_size:0] wbin;
  logic [addr_size:0] wbin_next;
  logic [addr_size:0] wgray_next;
  logic [addr_size:0] wptr_q;
  logic [addr_size:0] wq1_rptr;
  logic [addr_size:0] wq2_rptr;
  logic [addr_size:0] rbin_s;
  logic [addr_size:0] full_ptr;
  logic [addr_size:0] fill_next;
  logic [addr_size:0] wcount_q;
  logic               wfull_q;
  logic               walmost_full_q;
  logic               woverflow_q;
  logic               wen;

  always_comb begin
    wen        = bus.wput & ~wfull_q & wrst_n;
    wbin_next  = wbin + {{addr_size{1'b0}}, wen};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Each binary bit is the XOR of the Gray bits at and above it.
    rbin_s = '0;
    for (int unsigned i = 0; i <= addr_size; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
    full_ptr  = {~wq2_rptr[addr_size:addr_size-1], wq2_rptr[addr_size-2:0]};
    fill_next = wbin_next - rbin_s;
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wq1_rptr       <= '0;
      wq2_rptr       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wcount_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin           <= wbin_next;
      wptr_q         <= wgray_next;
      wq1_rptr       <= bus.rptr;
      wq2_rptr       <= wq1_rptr;
      wfull_q        <= (wgray_next == full_ptr);
      walmost_full_q <= (fill_next >= afull_level);
      wcount_q       <= fill_next;
      // A set request takes priority over a clear request that arrives in the same cycle.
      woverflow_q    <= (bus.wput & wfull_q) | (woverflow_q & ~bus.wclr_ovf);
    end
  end

  always_comb begin
    bus.wen          = wen;
    bus.waddr        = wbin[addr_size-1:0];
    bus.wptr         = wptr_q;
    bus.wfull        = wfull_q;
    bus.walmost_full = walmost_full_q;
    bus.wcount       = wcount_q;
    bus.woverflow    = woverflow_q;
  end
endmodule

// File: tb/tb_k_wctl_g.sv
// Bench for k_wctl_g: a constant vector table, hand-written corner sequences and random traffic.
// Every step is also checked against a fill-level model that uses plain write and read counts.
module tb_k_wctl_g;
  localparam int          AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFM   = 2;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  k_wctl_g_if #(.addr_size(AW)) bus ();
  k_wctl_g #(.addr_size(AW), .afull_margin(AFM)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus.slave)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: total accepted writes and read counts as seen through the two-flop synchroniser.
  int unsigned m_wr;
  int unsigned m_seen1;
  int unsigned m_seen2;
  int unsigned m_count;
  bit          m_full;
  bit          m_afull;
  bit          m_ovf;
  logic [AW:0] prev_wptr;

  typedef struct {
    bit          put;
    bit          clr;
    int unsigned rd;
    bit          full;
    bit          afull;
    int unsigned count;
    bit          ovf;
    logic [AW:0] wptr;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [AW:0] gray(input int unsigned b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit put, input bit clr, input int unsigned rd);
    bit          exp_wen;
    int unsigned fill;
    bus.wput     = put;
    bus.wclr_ovf = clr;
    bus.rptr     = gray(rd);
    #2;
    exp_wen = put && !m_full;
    chk("wen", 32'(bus.wen), 32'(exp_wen));
    chk("waddr", 32'(bus.waddr), m_wr % DEPTH);
    @(posedge wclk);
    #1;
    if (exp_wen) m_wr++;
    fill = (m_wr - m_seen2) % (2 * DEPTH);
    if (put && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    m_full  = (fill == DEPTH);
    m_afull = (fill >= DEPTH - AFM);
    m_count = fill;
    m_seen2 = m_seen1;
    m_seen1 = rd;
    chk("wptr", 32'(bus.wptr), 32'(gray(m_wr)));
    chk("wfull", 32'(bus.wfull), 32'(m_full));
    chk("walmost_full", 32'(bus.walmost_full), 32'(m_afull));
    chk("wcount", 32'(bus.wcount), m_count);
    chk("woverflow", 32'(bus.woverflow), 32'(m_ovf));
    chk("wptr_onebit", 32'($countones(bus.wptr ^ prev_wptr) <= 1), 32'd1);
    prev_wptr = bus.wptr;
  endtask

  task automatic do_reset(input int unsigned n);
    wrst_n       = 1'b0;
    bus.wput     = 1'b1;
    bus.wclr_ovf = 1'b0;
    bus.rptr     = gray(5);
    for (int unsigned k = 0; k < n; k++) begin
      #2;
      chk("wen_in_reset", 32'(bus.wen), 32'd0);
      @(posedge wclk);
      #1;
    end
    m_wr = 0; m_seen1 = 0; m_seen2 = 0; m_count = 0;
    m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
    prev_wptr = '0;
    chk("rst_wptr", 32'(bus.wptr), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wfull", 32'(bus.wfull), 32'd0);
    chk("rst_walmost_full", 32'(bus.walmost_full), 32'd0);
    chk("rst_wcount", 32'(bus.wcount), 32'd0);
    chk("rst_woverflow", 32'(bus.woverflow), 32'd0);
    wrst_n = 1'b1;
  endtask

  initial begin
    int unsigned hist[$];
    int unsigned rd;

    // Fill to full, provoke overflow, test clear and set-wins, then release four entries.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{put: 1'b1, clr: 1'b0, rd: 0, full: (i == 15), afull: (i >= 13),
                  count: 32'(i + 1), ovf: 1'b0, wptr: gray(32'(i + 1))};
    end
    vecs[16] = '{put: 1'b1, clr: 1'b0, rd: 0, full: 1'b1, afull: 1'b1, count: 16, ovf: 1'b1, wptr: 5'b11000};
    vecs[17] = '{put: 1'b0, clr: 1'b1, rd: 0, full: 1'b1, afull: 1'b1, count: 16, ovf: 1'b0, wptr: 5'b11000};
    vecs[18] = '{put: 1'b1, clr: 1'b1, rd: 0, full: 1'b1, afull: 1'b1, count: 16, ovf: 1'b1, wptr: 5'b11000};
    vecs[19] = '{put: 1'b0, clr: 1'b0, rd: 4, full: 1'b1, afull: 1'b1, count: 16, ovf: 1'b1, wptr: 5'b11000};
    vecs[20] = '{put: 1'b0, clr: 1'b0, rd: 4, full: 1'b1, afull: 1'b1, count: 16, ovf: 1'b1, wptr: 5'b11000};
    vecs[21] = '{put: 1'b0, clr: 1'b0, rd: 4, full: 1'b0, afull: 1'b0, count: 12, ovf: 1'b1, wptr: 5'b11000};

    bus.wput = 1'b1; bus.wclr_ovf = 1'b0; bus.rptr = '0;
    @(posedge wclk);
    #1;
    do_reset(2);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].put, vecs[i].clr, vecs[i].rd);
      chk("tbl_wfull", 32'(bus.wfull), 32'(vecs[i].full));
      chk("tbl_walmost_full", 32'(bus.walmost_full), 32'(vecs[i].afull));
      chk("tbl_wcount", 32'(bus.wcount), vecs[i].count);
      chk("tbl_woverflow", 32'(bus.woverflow), 32'(vecs[i].ovf));
      chk("tbl_wptr", 32'(bus.wptr), 32'(vecs[i].wptr));
    end

    // Edge-of-full: one read frees a slot while wput is held high.
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1);
    chk("eof_still_full", 32'(bus.wfull), 32'd1);
    chk("eof_wptr_held", 32'(bus.wptr), 32'(5'b11000));
    step(1'b1, 1'b0, 1);
    chk("eof_release", 32'(bus.wfull), 32'd0);
    chk("eof_count", 32'(bus.wcount), 32'd15);
    step(1'b1, 1'b0, 1);
    chk("eof_refull", 32'(bus.wfull), 32'd1);
    chk("eof_wptr_adv", 32'(bus.wptr), 32'(gray(17)));

    // Wrap: the reader trails the writer by four cycles.
    do_reset(1);
    for (int j = 1; j <= 40; j++) begin
      rd = (hist.size() >= 4) ? hist[hist.size() - 4] : 0;
      step(1'b1, 1'b0, rd);
      hist.push_back(m_wr);
      chk("wrap_nofull", 32'(bus.wfull), 32'd0);
      chk("wrap_count_le6", 32'(bus.wcount <= 6), 32'd1);
    end
    chk("wrap_wptr", 32'(bus.wptr), 32'(gray(40)));

    // Random traffic with occasional mid-run resets.
    do_reset(1);
    rd = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
        rd = 0;
      end else begin
        if (rd < m_wr && $urandom_range(0, 1) == 1) rd++;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
